sample_sequencer: RTL
=====================

# sample_sequencer

Frame-rate sequencer between the codec receive path and `dsp_pipeline`. Buffers incoming ADC samples in a small FIFO and issues exactly one `in_valid` pulse per sample when the pipeline reports `ready`. It tracks the pipeline's ready-low/ready-high completion handshake and captures the processed `out_sample` into a registered DAC-side output with a one-cycle strobe. It also counts overruns and detects hung pipelines with a timeout.

## Interface
- `data_width`, 16, sample width (signed, two's complement)
- `fifo_depth`, 4, input FIFO entries; power of two, ≥ 2
- `timeout_cycles`, 4096, max cycles in WAIT_DONE before timeout
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  high: route through pipeline; low: bypass
- `adc_sample`  in  data_width  sample from codec receiver
- `adc_valid`  in  1  one-cycle strobe per input sample
- `pipe_in_sample`  out  data_width  to pipeline `in_sample`; reset 0
- `pipe_in_valid`  out  1  to pipeline `in_valid`, one-cycle pulse; reset 0
- `pipe_ready`  in  1  from pipeline `ready`
- `pipe_out_sample`  in  data_width  from pipeline `out_sample`
- `dac_sample`  out  data_width  processed sample; reset 0
- `dac_valid`  out  1  one-cycle strobe on new `dac_sample`; reset 0
- `overrun_count`  out  16  dropped input samples, saturating; reset 0
- `timeout_flag`  out  1  sticky timeout or handshake error; cleared only by reset; reset 0
- `busy`  out  1  state ≠ IDLE or FIFO non-empty; reset 0

## Operation
- **FIFO write:** on `adc_valid` when `enable` is high.
  - Full and no pop in the same cycle: drop the new sample and increment `overrun_count`, saturating at 0xFFFF.
  - Full with a pop in the same cycle: accept the new sample.
- **States:** IDLE, WAIT_BUSY, WAIT_DONE, CAPTURE.
- **IDLE:**
  - Leaves IDLE when the FIFO is non-empty, `pipe_ready` is high and `enable` is high.
  - On leaving: pop the head into `pipe_in_sample`, assert `pipe_in_valid` for one cycle, go to WAIT_BUSY.
- **WAIT_BUSY:**
  - `pipe_ready` low → go to WAIT_DONE.
  - `pipe_ready` still high 3 cycles after the pulse → set `timeout_flag` and go to CAPTURE.
- **WAIT_DONE:**
  - `pipe_ready` high → go to CAPTURE.
  - Cycle counter reaches `timeout_cycles` → set `timeout_flag`, go to CAPTURE with the timeout path.
- **CAPTURE:**
  - Normal path: `dac_sample` ← `pipe_out_sample`, pulse `dac_valid`, return to IDLE.
  - Timeout path: see Configuration.
- **`enable` low:**
  - FIFO is flushed and held empty.
  - Each `adc_valid` copies `adc_sample` to `dac_sample` with a `dac_valid` pulse on the next cycle.
  - An in-flight transaction (any state ≠ IDLE) finishes normally, but its `dac_valid` is suppressed whenever a bypass `dac_valid` occurs in the same cycle. Bypass wins.
- Sample values pass unmodified; the block does no arithmetic on data. Counters are unsigned.

## Timing
- **Latency, empty FIFO, pipeline ready:**
  - `adc_valid` in cycle 0 → `pipe_in_valid` in cycle 1.
  - `pipe_ready` high first seen in cycle N → `dac_valid` in cycle N+1.
- **Pulse rules:**
  - `pipe_in_valid` is never asserted in two consecutive cycles.
  - `pipe_in_valid` is never asserted while state ≠ IDLE.
- **FIFO occupancy:** updates on the cycle after push/pop; `busy` is registered and follows it.
- **Reset:**
  - Asserting `reset` mid-transaction returns to IDLE immediately and empties the FIFO.
  - All outputs take their reset values asynchronously.
  - Deassertion is synchronised internally with a 2-flop synchroniser.

## Configuration
- `SAMPLE_SEQ_TIMEOUT_BYPASS_EN` defined: on the timeout path, CAPTURE outputs the raw input sample last sent to the pipeline, with `dac_valid` pulsed, so audio continues dry.
- Undefined: on the timeout path, `dac_sample` holds its previous value and `dac_valid` is still pulsed, so the frame count is preserved.
- Both builds set `timeout_flag` identically.

## Structure
- Shared package `sample_seq_pkg`:
  - state encoding constants (IDLE=0, WAIT_BUSY=1, WAIT_DONE=2, CAPTURE=3)
  - WAIT_BUSY limit constant (3)
- One sub-module: `sample_fifo`. Synchronous single-clock FIFO with push, pop, full, empty and registered head output.
- Sequencer FSM, counters and bypass mux live in the top level.

## Test plan
- Single sample 0x1234, pipeline model asserts ready low for 10 cycles and returns 0x0ABC → one `pipe_in_valid` carrying 0x1234, then `dac_valid` with 0x0ABC exactly 1 cycle after ready rises.
- Five `adc_valid` strobes back-to-back (fifo_depth 4) while pipeline busy → `overrun_count`=1, the four oldest samples processed in order, `busy` low at end.
- Pipeline model holds ready low forever → `timeout_flag` set after 4096 cycles in WAIT_DONE, and `dac_valid` pulsed:
  - with `SAMPLE_SEQ_TIMEOUT_BYPASS_EN`: `dac_sample` = input sample
  - without it: previous value held.
- Pipeline model never drops ready after the pulse → `timeout_flag` set 3 cycles after the pulse, capture occurs, FSM back to IDLE.
- `enable` low, `adc_valid` with 0x7FFF → `dac_sample`=0x7FFF with `dac_valid` the next cycle, no `pipe_in_valid`.
- `reset` asserted low during WAIT_DONE with 2 samples queued → all outputs zero immediately, FIFO empty after release, no spurious `dac_valid`.

Source files
------------

// File: rtl/sample_seq_pkg.sv
// Shared types and constants for the sample sequencer: FSM encoding,
// the WAIT_BUSY handshake limit and a saturating counter helper.
package sample_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_CAPTURE   = 2'd3
  } seq_state_t;

  // Cycles after the in_valid pulse that the pipeline may keep ready high.
  localparam int unsigned WAIT_BUSY_LIMIT = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with push/pop/flush, full/empty flags and the head
// entry presented straight from the storage registers. Depth must be a power of two.
module sample_fifo #(
  parameter int unsigned data_width = 16,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [data_width-1:0] i_data,
  output logic [data_width-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned AW   = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(fifo_depth);

  logic [data_width-1:0] r_mem [fifo_depth];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNTW-1:0]       r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sample_sequencer.sv
// Feeds buffered ADC samples to dsp_pipeline one at a time, tracks its ready
// handshake and registers the result for the DAC. Macro: SAMPLE_SEQ_TIMEOUT_BYPASS_EN.
module sample_sequencer
  import sample_seq_pkg::*;
#(
  parameter int unsigned data_width     = 16,
  parameter int unsigned fifo_depth     = 4,
  parameter int unsigned timeout_cycles = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [data_width-1:0] adc_sample,
  input  logic                  adc_valid,
  output logic [data_width-1:0] pipe_in_sample,
  output logic                  pipe_in_valid,
  input  logic                  pipe_ready,
  input  logic [data_width-1:0] pipe_out_sample,
  output logic [data_width-1:0] dac_sample,
  output logic                  dac_valid,
  output logic [15:0]           overrun_count,
  output logic                  timeout_flag,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int unsigned CW = $clog2(timeout_cycles + 1);
  localparam logic [CW-1:0] TO_LIMIT   = CW'(timeout_cycles);
  localparam logic [CW-1:0] BUSY_LIMIT = CW'(WAIT_BUSY_LIMIT);

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  seq_state_t            r_state;
  seq_state_t            w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  logic                  w_launch;
  logic                  w_capture;
  logic                  w_to_path;
  logic                  w_to_set;
  logic [data_width-1:0] r_last_sent;
  logic [data_width-1:0] r_dac;
  logic                  r_dac_valid;
  logic [15:0]           r_overrun;
  logic                  r_timeout;
  logic                  w_push_req;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [data_width-1:0] w_fifo_head;
  logic [data_width-1:0] w_capture_data;

  // Reset asserts asynchronously; release reaches the logic two edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_push_req = adc_valid && enable;

  sample_fifo #(
    .data_width (data_width),
    .fifo_depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_flush (!enable),
    .i_push  (w_push_req),
    .i_pop   (w_launch),
    .i_data  (adc_sample),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_launch     = 1'b0;
    w_capture    = 1'b0;
    w_to_path    = 1'b0;
    w_to_set     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && pipe_ready && enable) begin
          w_launch     = 1'b1;
          w_cnt_next   = CW'(1);
          w_state_next = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!pipe_ready) begin
          w_cnt_next   = CW'(1);
          w_state_next = ST_WAIT_DONE;
        end else if (r_cnt >= BUSY_LIMIT) begin
          // Pipeline never acknowledged: flag it, still close the frame.
          w_to_set     = 1'b1;
          w_capture    = 1'b1;
          w_state_next = ST_CAPTURE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (pipe_ready) begin
          w_capture    = 1'b1;
          w_state_next = ST_CAPTURE;
        end else if (r_cnt >= TO_LIMIT) begin
          w_to_set     = 1'b1;
          w_to_path    = 1'b1;
          w_capture    = 1'b1;
          w_state_next = ST_CAPTURE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_CAPTURE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_last_sent <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_launch) begin
        r_last_sent <= w_fifo_head;
      end
      if (w_to_set) begin
        r_timeout <= 1'b1;
      end
      if (w_push_req && w_fifo_full && !w_launch) begin
        r_overrun <= sat_inc16(r_overrun);
      end
    end
  end

`ifdef SAMPLE_SEQ_TIMEOUT_BYPASS_EN
  assign w_capture_data = w_to_path ? r_last_sent : pipe_out_sample;
`else
  assign w_capture_data = w_to_path ? r_dac : pipe_out_sample;
`endif

  // The capture is registered on the transition into CAPTURE so dac_valid
  // appears the cycle after ready is seen; a bypass strobe takes precedence.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dac       <= '0;
      r_dac_valid <= 1'b0;
    end else begin
      r_dac_valid <= 1'b0;
      if (adc_valid && !enable) begin
        r_dac       <= adc_sample;
        r_dac_valid <= 1'b1;
      end else if (w_capture) begin
        r_dac       <= w_capture_data;
        r_dac_valid <= 1'b1;
      end
    end
  end

  assign pipe_in_valid  = w_launch;
  assign pipe_in_sample = w_launch ? w_fifo_head : r_last_sent;
  assign dac_sample     = r_dac;
  assign dac_valid      = r_dac_valid;
  assign overrun_count  = r_overrun;
  assign timeout_flag   = r_timeout;
  assign busy           = (r_state != ST_IDLE) || !w_fifo_empty;
  assign dbg_state      = r_state;

endmodule
